sha_mem_responder: RTL and testbench
====================================

Name: sha_mem_responder

Overview:
- Word-addressed memory responder that serves the far end of the SHA engine memory interface (mem_we/mem_addr/mem_write_data/mem_read_data).
- Holds the message words to be hashed and receives the 8 hash output words.
- Second host port, arbitrated behind the engine, preloads messages and reads back digests while the engine is idle.
- Sits beside the hash engine in the top level and the testbench harness.

Parameters:
- DEPTH, 1024: number of 32-bit words stored.
- READ_LATENCY, 1: cycles from address sample to read data valid; legal range 1..4.

Ports:
- clk  in  1  single clock; all state sampled on rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_we  in  1  engine write enable.
- mem_addr  in  16  engine word address.
- mem_write_data  in  32  engine write data.
- mem_read_data  out  32  engine read data.
- eng_done  in  1  engine idle indication; host access allowed only while high.
- host_req  in  1  host access request; held until host_gnt.
- host_we  in  1  host write (1) / read (0).
- host_addr  in  16  host word address.
- host_wdata  in  32  host write data.
- host_gnt  out  1  one-cycle grant pulse.
- host_rvalid  out  1  one-cycle read-data-valid pulse.
- host_rdata  out  32  host read data, valid with host_rvalid.
- addr_err  out  1  sticky out-of-range flag.

Behaviour:
- Reset (async, reset=1):
  - mem_read_data, host_rdata = 0.
  - host_gnt, host_rvalid, addr_err = 0.
  - Read pipelines flushed; host FSM to H_IDLE.
  - Array contents not reset.
- Engine port is always active, with absolute priority:
  - Each cycle with mem_we=0 is a read of mem_addr; mem_read_data presents that word exactly READ_LATENCY cycles after the sampling edge and holds until the next pipeline stage updates it.
  - mem_we=1 writes mem_write_data at the edge; the read pipeline slot for that cycle carries the old (pre-write) word (read-first).
- Out-of-range addresses (addr >= DEPTH), either port:
  - Reads return 0.
  - Writes are dropped.
  - addr_err sets and stays set until reset.
- Host FSM states: H_IDLE, H_WAIT, H_RESP.
  - H_IDLE: if host_req=1 and eng_done=1, pulse host_gnt for one cycle and perform the access on that edge.
    - Write: back to H_IDLE.
    - Read: go to H_WAIT, loading wait counter = READ_LATENCY-1.
  - H_WAIT: decrement the counter; at 0 go to H_RESP.
  - H_RESP: host_rvalid=1 with host_rdata for one cycle, then H_IDLE.
  - At most one host transaction outstanding; next grant no earlier than the cycle after H_RESP.
- Host write latency: 1 cycle (grant cycle).
- Host read latency: READ_LATENCY+1 cycles from grant to rvalid.
- eng_done low while host_req is pending: no grant, request stalls.
- eng_done falls after grant: the outstanding host read completes normally.
- Engine write and host access to the same address in the same cycle: impossible by arbitration (host granted only with eng_done=1; the engine does not write while idle). If it occurs, the engine write wins and the host write is dropped.
- Reset mid-transaction: pending rvalid is lost; the array keeps already-written words.

Optional Feature:
- Macro: SHA_MEM_STATS_EN.
- Defined:
  - Adds outputs eng_rd_cnt[15:0] and eng_wr_cnt[15:0], saturating at 16'hFFFF, cleared by reset.
  - Counters increment per engine read cycle with eng_done=0, and per engine write cycle.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package sha_mem_pkg holds:
  - ADDR_W=16 and DATA_W=32 constants.
  - Host FSM state enum typedef {H_IDLE, H_WAIT, H_RESP}.
  - Out-of-range check function.
- Sub-module sha_mem_rd_pipe: parameterized READ_LATENCY delay line (data + valid), instantiated once per port.

Test Plan:
- Host writes 32'h61626380 to addr 0 with eng_done=1 -> host_gnt on the request cycle; a later host read of addr 0 gives host_rvalid with 32'h61626380 after READ_LATENCY+1 cycles.
- Engine reads addrs 0..19 back-to-back after host preload of words 32'h0000_0000+n -> mem_read_data = n exactly READ_LATENCY cycles after each address.
- Engine writes 8 hash words 32'hBA7816BF.. at addr 16'h0200; host reads them after eng_done=1 -> identical values in order.
- Engine write and read of addr 5 in the same cycle (old 32'h1111, new 32'h2222) -> that slot returns 32'h1111; the next read returns 32'h2222.
- host_req asserted while eng_done=0 for 10 cycles -> no host_gnt; grant occurs in the cycle eng_done rises.
- Access to addr 16'hFFFF -> read returns 0, write dropped, addr_err=1 until reset pulse clears it; with SHA_MEM_STATS_EN, counters match issued engine accesses.

Source files
------------

// File: rtl/sha_mem_pkg.sv
// sha_mem_pkg
// Shared constants, host-port FSM state type and the address range check used
// by the SHA engine memory responder and its read pipeline.
package sha_mem_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    H_IDLE = 2'd0,
    H_WAIT = 2'd1,
    H_RESP = 2'd2
  } host_state_t;

  // True when a word address falls inside a memory of 'depth' words.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input int unsigned depth);
    return 32'(addr) < depth;
  endfunction

endpackage

// File: rtl/sha_mem_rd_pipe.sv
// sha_mem_rd_pipe
// Fixed-length delay line for read data plus a valid bit. Stage 0 captures
// valid_in/data_in at the sampling edge, so data_out carries a word LATENCY
// cycles after its address was presented. Each data stage only loads when its
// upstream valid is set, so the last word seen is held through bubbles.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high; clears valid and data stages
//   valid_in   slot being captured this edge carries a read
//   data_in    word read for this slot
//   valid_out  last stage holds a fresh read this cycle
//   data_out   last stage data (held when no new read arrives)
module sha_mem_rd_pipe #(
  parameter int LATENCY = 1,
  parameter int WIDTH   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             valid_out,
  output logic [WIDTH-1:0] data_out
);

  logic [LATENCY-1:0] valid_q;
  logic [WIDTH-1:0]   data_q [LATENCY];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) data_q[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every stage
      // samples its upstream value from before this edge.
      valid_q[0] <= valid_in;
      if (valid_in) data_q[0] <= data_in;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign valid_out = valid_q[LATENCY-1];
  assign data_out  = data_q[LATENCY-1];

endmodule

// File: rtl/sha_mem_responder.sv
// sha_mem_responder
// Word-addressed memory serving the far end of the SHA engine memory
// interface. The engine port is always active and has absolute priority; a
// second host port, granted only while the engine reports idle (eng_done),
// preloads message words and reads back digests.
//
// Optional feature: define SHA_MEM_STATS_EN to add saturating engine access
// counters eng_rd_cnt / eng_wr_cnt.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   mem_we/mem_addr/mem_write_data/mem_read_data
//                       engine port; every cycle is a read-first access,
//                       read data appears READ_LATENCY cycles later
//   eng_done            engine idle; host access only while high
//   host_req/host_we/host_addr/host_wdata
//                       host request, held until host_gnt
//   host_gnt            one-cycle grant pulse (access happens on that edge)
//   host_rvalid/host_rdata
//                       host read response, READ_LATENCY+1 cycles after grant
//   addr_err            sticky flag: some access used an address >= DEPTH
//   eng_rd_cnt/eng_wr_cnt (SHA_MEM_STATS_EN only) engine access counters
module sha_mem_responder
  import sha_mem_pkg::*;
#(
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_write_data,
  output logic [DATA_W-1:0] mem_read_data,
  input  logic              eng_done,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              addr_err
`ifdef SHA_MEM_STATS_EN
  ,
  output logic [15:0]       eng_rd_cnt,
  output logic [15:0]       eng_wr_cnt
`endif
);

  localparam int          IDX_W     = $clog2(DEPTH);
  localparam logic [1:0]  WAIT_INIT = 2'(READ_LATENCY - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic             eng_in, host_in;
  logic [IDX_W-1:0] eng_idx, host_idx;

  assign eng_in   = addr_in_range(mem_addr, DEPTH);
  assign host_in  = addr_in_range(host_addr, DEPTH);
  assign eng_idx  = mem_addr[IDX_W-1:0];
  assign host_idx = host_addr[IDX_W-1:0];

  // ---------------------------------------------------------------------------
  // Host arbitration FSM
  // ---------------------------------------------------------------------------
  host_state_t state_q, state_d;
  logic [1:0]  wait_q, wait_d;
  logic        gnt_c;
  logic        host_wr, host_rd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= H_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_d = state_q;
    wait_d  = wait_q;
    gnt_c   = 1'b0;
    unique case (state_q)
      H_IDLE: begin
        if (host_req && eng_done && !reset) begin
          gnt_c = 1'b1;
          if (!host_we) begin
            state_d = H_WAIT;
            wait_d  = WAIT_INIT;
          end
        end
      end
      H_WAIT: begin
        if (wait_q == 2'd0) state_d = H_RESP;
        else                wait_d  = wait_q - 2'd1;
      end
      H_RESP:  state_d = H_IDLE;
      default: state_d = H_IDLE;
    endcase
  end

  assign host_gnt    = gnt_c;
  assign host_rvalid = (state_q == H_RESP);
  assign host_wr     = gnt_c & host_we;
  assign host_rd     = gnt_c & ~host_we;

  // ---------------------------------------------------------------------------
  // Storage. Single write port: the engine always wins, so a host write that
  // lands in an engine write cycle is dropped.
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset; only the small pipeline and control state
  // is cleared, and stored words survive a reset pulse.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (eng_in) mem[eng_idx] <= mem_write_data;
    end else if (host_wr && host_in) begin
      mem[host_idx] <= host_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipelines. Both sample the array before this edge's write lands,
  // giving read-first behaviour; out-of-range reads deliver zero.
  // ---------------------------------------------------------------------------
  logic              eng_pv, host_pv;
  logic [DATA_W-1:0] eng_pd, host_pd;
  logic [DATA_W-1:0] eng_word, host_word;

  assign eng_word  = eng_in  ? mem[eng_idx]  : '0;
  assign host_word = host_in ? mem[host_idx] : '0;

  sha_mem_rd_pipe #(.LATENCY(READ_LATENCY), .WIDTH(DATA_W)) u_eng_pipe (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (1'b1),
    .data_in   (eng_word),
    .valid_out (eng_pv),
    .data_out  (eng_pd)
  );

  sha_mem_rd_pipe #(.LATENCY(READ_LATENCY), .WIDTH(DATA_W)) u_host_pipe (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (host_rd),
    .data_in   (host_word),
    .valid_out (host_pv),
    .data_out  (host_pd)
  );

  // Until the first slot reaches the end of the pipe the engine sees zero.
  assign mem_read_data = eng_pv ? eng_pd : '0;

  // The host word leaves the pipe one cycle before H_RESP; this register
  // lines it up with host_rvalid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        host_rdata <= '0;
    else if (host_pv) host_rdata <= host_pd;
  end

  // Engine addresses are checked every cycle; host addresses only on grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             addr_err <= 1'b0;
    else if (!eng_in || (gnt_c && !host_in)) addr_err <= 1'b1;
  end

`ifdef SHA_MEM_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eng_rd_cnt <= '0;
      eng_wr_cnt <= '0;
    end else if (mem_we) begin
      if (eng_wr_cnt != 16'hFFFF) eng_wr_cnt <= eng_wr_cnt + 16'd1;
    end else if (!eng_done) begin
      if (eng_rd_cnt != 16'hFFFF) eng_rd_cnt <= eng_rd_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sha_mem_responder.sv
// tb_sha_mem_responder
// Randomized and directed stimulus for sha_mem_responder, checked every
// cycle against a cycle-indexed behavioural model of the memory, plus literal
// expectations for the known message/digest words.
module tb_sha_mem_responder;

  localparam int RL    = 2;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_we = 1'b0;
  logic [15:0] mem_addr = '0;
  logic [31:0] mem_write_data = '0;
  logic [31:0] mem_read_data;
  logic        eng_done = 1'b1;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [15:0] host_addr = '0;
  logic [31:0] host_wdata = '0;
  logic        host_gnt, host_rvalid, addr_err;
  logic [31:0] host_rdata;
`ifdef SHA_MEM_STATS_EN
  logic [15:0] eng_rd_cnt, eng_wr_cnt;
`endif

  sha_mem_responder #(.DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .eng_done       (eng_done),
    .host_req       (host_req),
    .host_we        (host_we),
    .host_addr      (host_addr),
    .host_wdata     (host_wdata),
    .host_gnt       (host_gnt),
    .host_rvalid    (host_rvalid),
    .host_rdata     (host_rdata),
    .addr_err       (addr_err)
`ifdef SHA_MEM_STATS_EN
    ,
    .eng_rd_cnt     (eng_rd_cnt),
    .eng_wr_cnt     (eng_wr_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: a word array with "known" flags, a ring of expected
  // engine read results indexed by cycle number, and the cycle in which the
  // single outstanding host read must answer.
  // ---------------------------------------------------------------------------
  logic [31:0] mm [DEPTH];
  bit          mk [DEPTH];
  logic [31:0] slot_val [16];
  bit          slot_kn  [16];
  int          cyc = 0, first_id = 0, rv_cyc = -100;
  logic [31:0] rv_val = '0;
  bit          rv_kn = 1'b0, err_m = 1'b0, g_m;
  int          rd_m = 0, wr_m = 0, s_m;

  function automatic bit in_rng(input logic [15:0] a);
    return int'(a) < DEPTH;
  endfunction

  function automatic bit gnt_model();
    return !reset && host_req && eng_done && (cyc > rv_cyc);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      first_id = cyc + 1;
      rv_cyc   = -100;
      err_m    = 1'b0;
      rd_m     = 0;
      wr_m     = 0;
    end else begin
      s_m = cyc % 16;
      slot_val[s_m] = in_rng(mem_addr) ? mm[mem_addr[9:0]] : 32'h0;
      slot_kn[s_m]  = in_rng(mem_addr) ? mk[mem_addr[9:0]] : 1'b1;
      if (!in_rng(mem_addr)) err_m = 1'b1;
      g_m = gnt_model();
      if (g_m && !in_rng(host_addr)) err_m = 1'b1;
      if (g_m && !host_we) begin
        rv_cyc = cyc + RL + 1;
        rv_val = in_rng(host_addr) ? mm[host_addr[9:0]] : 32'h0;
        rv_kn  = in_rng(host_addr) ? mk[host_addr[9:0]] : 1'b1;
      end
      if (mem_we) begin
        if (wr_m < 65535) wr_m++;
        if (in_rng(mem_addr)) begin
          mm[mem_addr[9:0]] = mem_write_data;
          mk[mem_addr[9:0]] = 1'b1;
        end
      end else begin
        if (!eng_done && rd_m < 65535) rd_m++;
        if (g_m && host_we && in_rng(host_addr)) begin
          mm[host_addr[9:0]] = host_wdata;
          mk[host_addr[9:0]] = 1'b1;
        end
      end
    end
    cyc++;
  end

  // Compare process: every output, every cycle, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      check("rst_mem_read_data", mem_read_data, 32'h0);
      check("rst_host_rdata", host_rdata, 32'h0);
      check("rst_host_gnt", host_gnt, 32'h0);
      check("rst_host_rvalid", host_rvalid, 32'h0);
      check("rst_addr_err", addr_err, 32'h0);
    end else begin
      check("host_gnt", host_gnt, gnt_model());
      check("host_rvalid", host_rvalid, cyc == rv_cyc);
      if (cyc == rv_cyc && rv_kn) check("host_rdata", host_rdata, rv_val);
      if (cyc - RL < first_id) check("eng_rdata_empty", mem_read_data, 32'h0);
      else if (slot_kn[(cyc - RL) % 16])
        check("eng_rdata", mem_read_data, slot_val[(cyc - RL) % 16]);
      check("addr_err", addr_err, err_m);
`ifdef SHA_MEM_STATS_EN
      check("eng_rd_cnt", eng_rd_cnt, rd_m);
      check("eng_wr_cnt", eng_wr_cnt, wr_m);
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One host transaction. Waits (bounded) for the grant, optionally drops
  // eng_done right after it, and for reads returns data and grant-to-rvalid
  // latency in cycles.
  task automatic host_access(input bit we, input logic [15:0] a, input logic [31:0] d,
                             input bit drop_done, output logic [31:0] rd, output int lat);
    bit got = 1'b0;
    rd  = '0;
    lat = 0;
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = host_gnt;
      tick();
    end
    host_req = 1'b0;
    if (!got) begin
      check("gnt_timeout", 32'h0, 32'h1);
      return;
    end
    if (drop_done) eng_done = 1'b0;
    if (!we) begin
      got = 1'b0;
      for (int k = 1; k <= 20 && !got; k++) begin
        @(negedge clk);
        if (host_rvalid) begin
          got = 1'b1;
          lat = k;
          rd  = host_rdata;
        end
        tick();
      end
      if (!got) check("rvalid_timeout", 32'h0, 32'h1);
    end
    if (drop_done) eng_done = 1'b1;
  endtask

  logic [31:0] hash_w [8];
  logic [31:0] rd;
  int          lat;
  bit          rwe;

  initial begin
    hash_w[0] = 32'hBA7816BF; hash_w[1] = 32'h8F01CFEA;
    hash_w[2] = 32'h414140DE; hash_w[3] = 32'h5DAE2223;
    hash_w[4] = 32'hB00361A3; hash_w[5] = 32'h96177A9C;
    hash_w[6] = 32'hB410FF61; hash_w[7] = 32'hF20015AD;

    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Host write then read of the first message word.
    host_access(1'b1, 16'h0000, 32'h61626380, 1'b0, rd, lat);
    host_access(1'b0, 16'h0000, 32'h0, 1'b0, rd, lat);
    check("t1_rdata", rd, 32'h61626380);
    check("t1_rd_latency", lat, RL + 1);

    // Preload words n, then back-to-back engine reads.
    for (int n = 0; n < 20; n++) host_access(1'b1, 16'(n), 32'(n), 1'b0, rd, lat);
    eng_done = 1'b0;
    for (int i = 0; i < 20 + RL; i++) begin
      mem_addr = (i < 20) ? 16'(i) : 16'h0;
      @(negedge clk);
      if (i >= RL) check("t2_eng_seq", mem_read_data, 32'(i - RL));
      tick();
    end

    // Engine writes digest words, host reads them back.
    for (int i = 0; i < 8; i++) begin
      mem_we = 1'b1; mem_addr = 16'h0200 + 16'(i); mem_write_data = hash_w[i];
      tick();
    end
    mem_we = 1'b0; mem_addr = 16'h0;
    eng_done = 1'b1;
    for (int i = 0; i < 8; i++) begin
      host_access(1'b0, 16'h0200 + 16'(i), 32'h0, 1'b0, rd, lat);
      check("t3_digest", rd, hash_w[i]);
    end

    // Read-first: write and read of addr 5 in the same cycle.
    host_access(1'b1, 16'd5, 32'h1111, 1'b0, rd, lat);
    eng_done = 1'b0;
    for (int i = 0; i < 2 + RL; i++) begin
      mem_we = (i == 0); mem_addr = 16'd5; mem_write_data = 32'h2222;
      @(negedge clk);
      if (i == RL)     check("t4_old_word", mem_read_data, 32'h1111);
      if (i == RL + 1) check("t4_new_word", mem_read_data, 32'h2222);
      tick();
    end
    mem_we = 1'b0; mem_addr = 16'h0;

    // Host request stalls while the engine is busy.
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'd7; host_wdata = 32'h0000_0077;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t5_stall_gnt", host_gnt, 32'h0);
      tick();
    end
    eng_done = 1'b1;
    @(negedge clk);
    check("t5_gnt_on_done", host_gnt, 32'h1);
    tick();
    host_req = 1'b0;
    // eng_done falls right after the grant; the read still completes.
    host_access(1'b0, 16'd7, 32'h0, 1'b1, rd, lat);
    check("t5_drop_done_rdata", rd, 32'h0000_0077);
    check("t5_drop_done_lat", lat, RL + 1);

    // Random engine bursts interleaved with random host traffic.
    for (int r = 0; r < 12; r++) begin
      eng_done = 1'b0;
      for (int n = $urandom_range(3, 20); n > 0; n--) begin
        mem_we = 1'($urandom_range(0, 1));
        mem_addr = 16'($urandom_range(0, 63));
        mem_write_data = $urandom;
        tick();
      end
      mem_we = 1'b0;
      eng_done = 1'b1;
      for (int n = $urandom_range(1, 4); n > 0; n--) begin
        mem_addr = 16'($urandom_range(0, 63));
        rwe = 1'($urandom_range(0, 1));
        host_access(rwe, 16'($urandom_range(0, 63)), $urandom,
                    $urandom_range(0, 3) == 0, rd, lat);
        if (!rwe) check("rand_rd_lat", lat, RL + 1);
      end
    end
    mem_addr = 16'h0;

    // Out-of-range accesses: zero data, dropped writes, sticky flag.
    host_access(1'b1, 16'd1023, 32'hA5A5_A5A5, 1'b0, rd, lat);
    eng_done = 1'b0;
    mem_we = 1'b1; mem_addr = 16'hFFFF; mem_write_data = 32'hDEAD_BEEF;
    tick();
    mem_we = 1'b0; mem_addr = 16'h0;
    @(negedge clk);
    check("t6_err_set", addr_err, 32'h1);
    for (int i = 0; i <= RL; i++) begin
      mem_addr = (i == 0) ? 16'hFFFF : 16'h0;
      @(negedge clk);
      if (i == RL) check("t6_eng_oor_rd", mem_read_data, 32'h0);
      tick();
    end
    eng_done = 1'b1;
    host_access(1'b0, 16'd1023, 32'h0, 1'b0, rd, lat);
    check("t6_no_alias_write", rd, 32'hA5A5_A5A5);
    host_access(1'b0, 16'hFFFF, 32'h0, 1'b0, rd, lat);
    check("t6_host_oor_rd", rd, 32'h0);
    check("t6_err_sticky", addr_err, 32'h1);
    reset = 1'b1;
    tick();
    check("t6_err_cleared", addr_err, 32'h0);
    reset = 1'b0;
    tick();
    check("t6_err_stays_clear", addr_err, 32'h0);
    host_access(1'b0, 16'h0200, 32'h0, 1'b0, rd, lat);
    check("t6_array_kept", rd, 32'hBA7816BF);

    // Reset during an outstanding host read drops the response.
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0201;
    @(negedge clk);
    check("t7_gnt", host_gnt, 32'h1);
    tick();
    host_req = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < RL + 3; i++) begin
      @(negedge clk);
      check("t7_lost_rvalid", host_rvalid, 32'h0);
      tick();
    end
    host_access(1'b0, 16'h0201, 32'h0, 1'b0, rd, lat);
    check("t7_reread", rd, 32'h8F01CFEA);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
